// File: rtl/temporal_cmp_bank.sv
// temporal_cmp_bank: multi-channel race-logic comparator (GE/LT/MIN/MAX) with timestamped fixed-width pulses
module temporal_cmp_bank #(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                              aclk,
  input  logic                              grst,
  input  logic                              gamma_start_i,
  input  logic [2*N_CH-1:0]                 mode_i,
  input  logic [N_CH-1:0]                   a_i,
  input  logic [N_CH-1:0]                   b_i,
  output logic [N_CH-1:0]                   q_o,
  output logic [N_CH-1:0]                   q_valid_o,
  output logic [N_CH*GAMMA_CYCLE_WIDTH-1:0] t_q_o
);
  localparam int W  = GAMMA_CYCLE_WIDTH;
  localparam int CW = $clog2(PULSE_WIDTH + 1);
  localparam logic [1:0] M_GE = 2'b00, M_LT = 2'b01, M_MIN = 2'b10, M_MAX = 2'b11;
  typedef enum logic [2:0] {IDLE, ARMED, HALF, PULSE, DONE} state_t;
  logic [W-1:0] tnow_q;
  always_ff @(posedge aclk or posedge grst)
    if (grst) tnow_q <= '0;
    else if (gamma_start_i) tnow_q <= '0;
    else if (tnow_q != '1) tnow_q <= tnow_q + 1'b1;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t         st_q, st_d;
    logic [1:0]     md_q, md_d;
    logic           af_q, af_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           q_q, q_d, qv_q, qv_d, fire, hold;
    logic [W-1:0]   tq_q, tq_d;
    always_comb begin
      st_d  = st_q;
      md_d  = md_q;
      af_d  = af_q;
      cnt_d = cnt_q;
      q_d   = q_q;
      qv_d  = 1'b0;
      tq_d  = tq_q;
      fire  = 1'b0;
      hold  = 1'b0;
      if (gamma_start_i) begin
        st_d  = ARMED;
        md_d  = mode_i[2*i +: 2];
        af_d  = 1'b0;
        cnt_d = '0;
        q_d   = 1'b0;
        tq_d  = '0;
      end else begin
        case (st_q)
          ARMED: if (a_i[i] || b_i[i]) begin
            fire = md_q == M_MIN ? 1'b1 :
                   md_q == M_LT  ? a_i[i] && !b_i[i] : a_i[i] && b_i[i];
            // a single arrival is only worth waiting on when the other input can still fire it
            hold = (md_q == M_MAX && a_i[i] != b_i[i]) || (md_q == M_GE && b_i[i] && !a_i[i]);
            st_d = fire ? PULSE : hold ? HALF : DONE;
            af_d = a_i[i];
          end
          HALF: if (af_q ? b_i[i] : a_i[i]) begin
            fire = 1'b1;
            st_d = PULSE;
          end
          PULSE: if (cnt_q == CW'(PULSE_WIDTH - 1)) begin
            q_d  = 1'b0;
            st_d = DONE;
          end else cnt_d = cnt_q + 1'b1;
          default: ;
        endcase
        if (fire) begin
          q_d   = 1'b1;
          qv_d  = 1'b1;
          tq_d  = tnow_q;
          cnt_d = '0;
        end
      end
    end
    always_ff @(posedge aclk or posedge grst)
      if (grst) begin
        st_q  <= IDLE;
        md_q  <= M_GE;
        af_q  <= 1'b0;
        cnt_q <= '0;
        q_q   <= 1'b0;
        qv_q  <= 1'b0;
        tq_q  <= '0;
      end else begin
        st_q  <= st_d;
        md_q  <= md_d;
        af_q  <= af_d;
        cnt_q <= cnt_d;
        q_q   <= q_d;
        qv_q  <= qv_d;
        tq_q  <= tq_d;
      end
    assign q_o[i]            = q_q;
    assign q_valid_o[i]      = qv_q;
    assign t_q_o[i*W +: W]   = tq_q;
  end
endmodule
